// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, device-clocked bits and line ack.
// Define PS2_TX_TIMEOUT_EN to add a whole-frame watchdog that abandons a frame from a silent device.

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] dat_i,
  input  logic        we_i,
  input  logic        stb_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic        tx_busy
);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

  localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [1:0]  r_clkSync, r_datSync;
  logic        r_clkPrev;
  logic [7:0]  r_txByte;
  logic        r_par;
  logic [3:0]  r_bitCnt;
  logic        r_dataLow;
  logic        r_nack;
  logic [31:0] r_inhCnt;
  logic        r_done, r_err, r_ovr;
  logic        w_wr, w_rd, w_fe, w_txBit, w_timeout, w_setErr, w_setDone;
  logic        w_unused;

  assign w_wr    = stb_i & we_i;
  assign w_rd    = stb_i & ~we_i;
  assign w_fe    = r_clkPrev & ~r_clkSync[1];
  assign tx_busy = (r_state != IDLE);
  assign ack_o   = stb_i;
  assign dat_o   = {20'h0, r_ovr, r_err, r_done, tx_busy, r_txByte};

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_wdog;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      r_wdog <= '0;
    else if (r_state == IDLE || r_state == INHIBIT)
      r_wdog <= '0;
    else
      r_wdog <= r_wdog + 32'd1;
  end

  assign w_timeout = (r_state != IDLE) && (r_state != INHIBIT) && (r_wdog == TO_LAST);
  assign w_unused  = &{1'b0, dat_i[31:8]};
`else
  assign w_timeout = 1'b0;
  assign w_unused  = &{1'b0, dat_i[31:8], 32'(TIMEOUT_CYCLES)};
`endif

  // Pins idle high after reset so a freshly released line never looks like a falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
      r_clkPrev <= 1'b1;
    end else begin
      r_clkSync <= {r_clkSync[0], ps2_clk_i};
      r_datSync <= {r_datSync[0], ps2_data_i};
      r_clkPrev <= r_clkSync[1];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    w_setErr    = 1'b0;
    w_setDone   = 1'b0;
    if (r_bitCnt < 4'd8)
      w_txBit = r_txByte[r_bitCnt[2:0]];
    else if (r_bitCnt == 4'd8)
      w_txBit = r_par;
    else
      w_txBit = 1'b1;
    case (r_state)
      IDLE:      if (w_wr) w_next = INHIBIT;
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (r_inhCnt == INH_LAST) w_next = RTS;
      end
      RTS: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        w_next      = SEND;
      end
      SEND: begin
        ps2_data_oe = r_dataLow;
        if (w_fe && r_bitCnt == 4'd9) w_next = ACK;
      end
      ACK: if (w_fe) begin
        w_next   = WAIT_IDLE;
        w_setErr = r_datSync[1];
      end
      WAIT_IDLE: if (r_clkSync[1] && r_datSync[1]) begin
        w_next    = IDLE;
        w_setDone = ~r_nack;
      end
      default:   w_next = IDLE;
    endcase
    if (w_timeout) begin
      w_next      = IDLE;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      w_setErr    = 1'b1;
      w_setDone   = 1'b0;
    end
  end

  // The start bit is held low from RTS until the device's first falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_inhCnt  <= '0;
      r_bitCnt  <= '0;
      r_dataLow <= 1'b0;
      r_txByte  <= '0;
      r_par     <= 1'b0;
      r_nack    <= 1'b0;
    end else begin
      r_inhCnt <= (r_state == INHIBIT) ? r_inhCnt + 32'd1 : '0;
      if (r_state == RTS) begin
        r_dataLow <= 1'b1;
        r_bitCnt  <= '0;
      end else if (r_state == SEND && w_fe) begin
        r_dataLow <= ~w_txBit;
        r_bitCnt  <= r_bitCnt + 4'd1;
      end
      if (r_state == IDLE && w_wr) begin
        r_txByte <= dat_i[7:0];
        r_par    <= ~^dat_i[7:0];
        r_nack   <= 1'b0;
      end
      if (r_state == ACK && w_fe)
        r_nack <= r_datSync[1];
    end
  end

  // Clears come first so a same-cycle set event wins.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_rd) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_ovr  <= 1'b0;
      end
      if (r_state == IDLE && w_wr) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_wr && r_state != IDLE) r_ovr  <= 1'b1;
      if (w_setErr)                r_err  <= 1'b1;
      if (w_setDone)               r_done <= 1'b1;
    end
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: accepts a command byte (e.g. keyboard 0xED LED set, 0xFF reset) from the CPU over the same single-register strobe/ack bus used by the PS/2 receive port. It drives the open-drain PS/2 clock and data lines through the inhibit, request-to-send, device-clocked bit transfer and line-ack sequence. It sits beside the `ps2_kbd` receiver on the same pins; `tx_busy` gates the receiver while the host owns the line.

## Interface
- `INHIBIT_CYCLES`, 5000, clock-low inhibit length in `clk` cycles (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000, whole-frame watchdog limit in `clk` cycles (15 ms at 50 MHz); used only with `PS2_TX_TIMEOUT_EN`.
- `clk`, in, 1, the block's only clock; every register in the block is clocked on its rising edge.
- `clrn`, in, 1, asynchronous active-low reset.
- `dat_i`, in, 32, write data; only [7:0] is used.
- `we_i`, in, 1, write enable.
- `stb_i`, in, 1, bus strobe.
- `dat_o`, out, 32, status word, combinational.
- `ack_o`, out, 1, equals `stb_i`.
- `ps2_clk_i`, in, 1, PS/2 clock pin value (asynchronous).
- `ps2_data_i`, in, 1, PS/2 data pin value (asynchronous).
- `ps2_clk_oe`, out, 1, 1 drives the clock pin low; 0 releases it.
- `ps2_data_oe`, out, 1, 1 drives the data pin low; 0 releases it.
- `tx_busy`, out, 1, high in every state except IDLE.

## Operation
- Input sync: `ps2_clk_i` and `ps2_data_i` each pass through two flip-flops. A falling edge (`fe`) is asserted when the previous synced clock value is 1 and the current value is 0.
- Write rules:
  - A write is `stb_i & we_i`.
  - In IDLE, a write latches `dat_i[7:0]` into `tx_byte` and computes odd parity `par = ~^tx_byte`.
  - In any other state, a write is dropped and sticky `ovr` is set; `tx_byte` is unchanged.
- Status word: `dat_o = {20'h0, ovr, err, done, tx_busy, tx_byte}`.
- Read-to-clear: a read (`stb_i & ~we_i`) clears `done`, `err` and `ovr` at that clock edge. If a set event and a clear occur in the same cycle, the set wins.
- A write in IDLE also clears `done` and `err`.
- FSM states:
  - IDLE: both `oe` low. A write moves to INHIBIT.
  - INHIBIT: `ps2_clk_oe=1` for `INHIBIT_CYCLES` cycles, then go to RTS.
  - RTS: `ps2_clk_oe=1`, `ps2_data_oe=1` for exactly 1 cycle (start bit = 0), then go to SEND with `bitcnt=0`.
  - SEND: clock released. On each `fe`, drive the bit at index `bitcnt` and increment `bitcnt`:
    - indices 0–7: `tx_byte[bitcnt]`, LSB first;
    - index 8: `par`;
    - index 9: stop bit, data released.
    - A 1 bit means `ps2_data_oe=0`; a 0 bit means `ps2_data_oe=1`.
    - After the 10th `fe`, go to ACK.
  - ACK: data released. On the next `fe`, sample synced data: 0 means ack OK; 1 sets `err`. Go to WAIT_IDLE.
  - WAIT_IDLE: when synced clock and data are both 1, go to IDLE. Set `done=1` only if no error occurred.
- `bitcnt` is 4 bits. Edges are ignored in IDLE, INHIBIT and RTS.

## Timing
- Reset values:
  - Outputs: `ps2_clk_oe=0`, `ps2_data_oe=0`, `tx_busy=0`, `dat_o=0`.
  - Internal: state IDLE, `tx_byte=0`, `done=err=ovr=0`.
- Reset mid-frame releases both lines immediately (asynchronously); the frame is abandoned without setting `err`.
- Write at edge N: `tx_busy=1` and `ps2_clk_oe=1` from cycle N+1.
  - `ps2_clk_oe` stays high through cycle N+`INHIBIT_CYCLES`+1; the last of those cycles is RTS, with `ps2_data_oe=1`.
- Pin-to-`fe` latency is 3 cycles. The data output updates on the cycle `fe` is asserted.
- The device samples data on the clock rising edge; the PS/2 half period (≥30 µs) far exceeds this latency.
- `ack_o` is combinational and the bus never stalls.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A watchdog counter starts at INHIBIT exit and clears in IDLE.
  - If it reaches `TIMEOUT_CYCLES` before IDLE, the block releases both lines, sets `err=1`, leaves `done=0`, and returns to IDLE the next cycle.
- `PS2_TX_TIMEOUT_EN` undefined: no counter. The FSM waits indefinitely, and only `clrn` recovers a silent device.

## Test plan
- Write 0xED, device model clocks 11 edges and acks low:
  - `ps2_clk_oe` is high for 5001 cycles.
  - The model samples 0,1,0,1,1,0,1,1,1,1,1 (start, bits LSB first, parity 1, stop).
  - `dat_o` reads 0x2ED; a second read returns 0x0ED.
- Write 0x01: parity sampled 0; write 0xFF: parity sampled 1; both end with `done=1`.
- Device leaves data high at the 11th edge -> `err=1`, `done=0`, `dat_o[10]=1`.
- Write 0x55 then 0x33 while `tx_busy` -> `tx_byte` stays 0x55 and `ovr=1`; a read clears it.
- With `PS2_TX_TIMEOUT_EN` and `TIMEOUT_CYCLES=2000`, device never clocks -> both `oe=0` and `err=1` by cycle 5002+2001 after the write.
- `clrn` low during SEND bit 4 -> both `oe=0` at once and `tx_busy=0`; a following write of 0xF4 completes normally.
